// File: rtl/master_spi_pkg.sv
// master_spi_pkg: shared definitions for the master_spi SPI master.
//   state_e              FSM state encoding (IDLE, LOW, HIGH, GAP)
//   DEFAULT_HALF_PERIOD  default system clocks per SCK half period
//   SPI_WIDTH            bits per transfer
package master_spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    GAP  = 2'd3
  } state_e;

  localparam int unsigned DEFAULT_HALF_PERIOD = 197;
  localparam int unsigned SPI_WIDTH           = 8;

endpackage

// File: rtl/master_spi_prescaler.sv
// master_spi_prescaler: half-period counter for the SPI master.
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   restart_i    holds the counter at 0 (used while the FSM is idle)
//   phase_end_o  one-cycle pulse in the last cycle of each half period
// The counter runs 0..HALF_PERIOD-1 and wraps on its own, so every phase
// change restarts it without extra control.
module master_spi_prescaler
  import master_spi_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = DEFAULT_HALF_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic phase_end_o
);

  localparam int unsigned      CNT_W    = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_end_o = (cnt_q == CNT_LAST) && !restart_i;

endmodule

// File: rtl/master_spi.sv
// master_spi: single-byte SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
//   Clock    system clock, rising edge
//   Reset    synchronous active-high reset
//   Start_i  transfer request, sampled while Busy_o=0
//   Data_i   byte to transmit, captured on the accepting edge
//   Busy_o   high from the cycle after acceptance until Done_o
//   Done_o   one-cycle pulse at the end of a transfer
//   Data_o   byte received on MISO, updated with Done_o
//   CS_o     chip select, active low
//   SCK_o    serial clock, idles low
//   MOSI_o   serial data out
//   MISO_i   serial data in (used unsynchronized, stable at SCK fall)
// Build option: define MASTER_SPI_RX_EN to implement the receive path;
// without it MISO_i is ignored and Data_o is constant zero.
module master_spi
  import master_spi_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = DEFAULT_HALF_PERIOD
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Start_i,
  input  logic [SPI_WIDTH-1:0] Data_i,
  output logic                 Busy_o,
  output logic                 Done_o,
  output logic [SPI_WIDTH-1:0] Data_o,
  output logic                 CS_o,
  output logic                 SCK_o,
  output logic                 MOSI_o,
  input  logic                 MISO_i
);

  state_e               state_q, state_d;
  logic                 cs_q, cs_d;
  logic                 sck_q, sck_d;
  logic                 mosi_q, mosi_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  // Bit 7 goes straight to MOSI on acceptance, so only the remaining
  // seven bits are kept for shifting.
  logic [SPI_WIDTH-2:0] tx_q, tx_d;
  logic [2:0]           bit_q, bit_d;
  logic                 phase_end;

  master_spi_prescaler #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_prescaler (
    .clk        (Clock),
    .rst        (Reset),
    .restart_i  (state_q == IDLE),
    .phase_end_o(phase_end)
  );

  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tx_d    = tx_q;
    bit_d   = bit_q;
    unique case (state_q)
      IDLE: begin
        if (Start_i && !busy_q) begin
          tx_d    = Data_i[SPI_WIDTH-2:0];
          bit_d   = 3'd7;
          mosi_d  = Data_i[SPI_WIDTH-1];
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = LOW;
        end
      end
      LOW: begin
        if (phase_end) begin
          sck_d   = 1'b1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (phase_end) begin
          sck_d = 1'b0;
          if (bit_q != 3'd0) begin
            bit_d   = bit_q - 3'd1;
            mosi_d  = tx_q[SPI_WIDTH-2];
            tx_d    = {tx_q[SPI_WIDTH-3:0], 1'b0};
            state_d = LOW;
          end else begin
            cs_d    = 1'b1;
            mosi_d  = 1'b0;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (phase_end) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tx_q    <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tx_q    <= tx_d;
      bit_q   <= bit_d;
    end
  end

`ifdef MASTER_SPI_RX_EN
  logic                 sample_rx;
  logic                 load_data;
  logic [SPI_WIDTH-1:0] rx_q, rx_d;
  logic [SPI_WIDTH-1:0] data_q, data_d;

  // MISO is taken on the edge that ends HIGH, i.e. together with SCK fall.
  assign sample_rx = (state_q == HIGH) && phase_end;
  assign load_data = (state_q == GAP) && phase_end;

  always_comb begin
    rx_d   = rx_q;
    data_d = data_q;
    if (sample_rx) begin
      rx_d = {rx_q[SPI_WIDTH-2:0], MISO_i};
    end
    if (load_data) begin
      data_d = rx_q;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rx_q   <= '0;
      data_q <= '0;
    end else begin
      rx_q   <= rx_d;
      data_q <= data_d;
    end
  end

  assign Data_o = data_q;
`else
  logic unused_miso;
  assign unused_miso = MISO_i;
  assign Data_o      = '0;
`endif

  assign CS_o   = cs_q;
  assign SCK_o  = sck_q;
  assign MOSI_o = mosi_q;
  assign Busy_o = busy_q;
  assign Done_o = done_q;

endmodule

// File: tb/tb_master_spi.sv
// tb_master_spi: directed, table-driven bench for master_spi with
// HALF_PERIOD=4. Cycle n below is the value seen just before the n-th
// clock edge after the accepting edge (cycle 0).
module tb_master_spi;

  localparam int unsigned HP = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] din;
  logic [7:0] dout;
  logic       busy, done, cs, sck, mosi, miso;
  logic       loop_en;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign miso = loop_en ? mosi : 1'b0;

  master_spi #(
    .HALF_PERIOD(HP)
  ) dut (
    .Clock  (clk),
    .Reset  (rst),
    .Start_i(start),
    .Data_i (din),
    .Busy_o (busy),
    .Done_o (done),
    .Data_o (dout),
    .CS_o   (cs),
    .SCK_o  (sck),
    .MOSI_o (mosi),
    .MISO_i (miso)
  );

  typedef struct {
    logic [7:0]  data;
    logic        loop;
    int unsigned pulse_at;
    logic        hold;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] exp_prev;

  task automatic chk(input string name, input int c, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %h want %h", name, c, act, exp);
    end
  endtask

  function automatic logic [7:0] rx_expect(input logic [7:0] d, input logic lp);
`ifdef MASTER_SPI_RX_EN
    return lp ? d : 8'h00;
`else
    return 8'h00;
`endif
  endfunction

  function automatic logic e_cs(input int c, input logic hold);
    if (c >= 1 && c <= 64) return 1'b0;
    if (hold && c == 70) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic e_sck(input int c);
    if (c >= 1 && c <= 64) return (((c - 1) / HP) % 2) == 1;
    return 1'b0;
  endfunction

  function automatic logic e_mosi(input int c, input logic [7:0] d, input logic hold);
    if (c >= 1 && c <= 64) return d[7 - ((c - 1) / (2 * HP))];
    if (hold && c == 70) return d[7];
    return 1'b0;
  endfunction

  function automatic logic e_busy(input int c, input logic hold);
    if (c >= 1 && c <= 68) return 1'b1;
    if (hold && c == 70) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_done(input string name, input logic [7:0] exp);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s timeout: got no Done_o want Done_o within 200 cycles", name);
    end else begin
      chk({name, "_data"}, 0, dout, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] d;
    logic [7:0] exp_new;
    d       = v.data;
    exp_new = rx_expect(d, v.loop);
    loop_en = v.loop;
    @(negedge clk);
    start = 1'b1;
    din   = d;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      chk("cs",   c, {7'd0, cs},   {7'd0, e_cs(c, v.hold)});
      chk("sck",  c, {7'd0, sck},  {7'd0, e_sck(c)});
      chk("mosi", c, {7'd0, mosi}, {7'd0, e_mosi(c, d, v.hold)});
      chk("busy", c, {7'd0, busy}, {7'd0, e_busy(c, v.hold)});
      chk("done", c, {7'd0, done}, {7'd0, (c == 69)});
      chk("data_o", c, dout, (c >= 69) ? exp_new : exp_prev);
      if (!v.hold) begin
        start = 1'b0;
        din   = ~d;
      end
      if (v.pulse_at != 0 && c == int'(v.pulse_at)) begin
        start = 1'b1;
        din   = 8'hFF;
      end
    end
    start    = 1'b0;
    exp_prev = exp_new;
    if (v.hold) begin
      wait_done("hold_second", exp_new);
      @(negedge clk);
      chk("hold_idle_cs", 0, {7'd0, cs}, 8'h01);
      chk("hold_idle_busy", 0, {7'd0, busy}, 8'h00);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish want finish within 2ms");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{data: 8'h55, loop: 1'b0, pulse_at: 0,  hold: 1'b0};
    vecs[1] = '{data: 8'h33, loop: 1'b1, pulse_at: 0,  hold: 1'b0};
    vecs[2] = '{data: 8'h0F, loop: 1'b1, pulse_at: 0,  hold: 1'b0};
    vecs[3] = '{data: 8'h00, loop: 1'b1, pulse_at: 0,  hold: 1'b0};
    vecs[4] = '{data: 8'h55, loop: 1'b0, pulse_at: 20, hold: 1'b0};
    vecs[5] = '{data: 8'h0F, loop: 1'b1, pulse_at: 0,  hold: 1'b1};

    rst      = 1'b1;
    start    = 1'b0;
    din      = 8'h00;
    loop_en  = 1'b0;
    exp_prev = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cs",   0, {7'd0, cs},   8'h01);
    chk("rst_sck",  0, {7'd0, sck},  8'h00);
    chk("rst_mosi", 0, {7'd0, mosi}, 8'h00);
    chk("rst_busy", 0, {7'd0, busy}, 8'h00);
    chk("rst_done", 0, {7'd0, done}, 8'h00);
    chk("rst_data", 0, dout,         8'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
    end

    // Reset in the middle of a transfer.
    loop_en = 1'b1;
    @(negedge clk);
    start = 1'b1;
    din   = 8'hC3;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 29) begin
        chk("pre_rst_cs", c, {7'd0, cs}, 8'h00);
        rst = 1'b1;
      end
      if (c == 30) begin
        chk("mid_rst_cs",   c, {7'd0, cs},   8'h01);
        chk("mid_rst_sck",  c, {7'd0, sck},  8'h00);
        chk("mid_rst_mosi", c, {7'd0, mosi}, 8'h00);
        chk("mid_rst_busy", c, {7'd0, busy}, 8'h00);
        chk("mid_rst_done", c, {7'd0, done}, 8'h00);
        chk("mid_rst_data", c, dout,         8'h00);
        rst = 1'b0;
      end
    end
    for (int c = 31; c <= 110; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || cs !== 1'b1) begin
        chk("post_rst_quiet", c, {6'd0, done, cs}, 8'h01);
      end
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL post_rst_busy: got %b want 0", busy);
    end
    exp_prev = 8'h00;
    run_vec('{data: 8'hA5, loop: 1'b1, pulse_at: 0, hold: 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
